// File: rtl/eeg_pkg.sv
// eeg_pkg: shared FSM state type, default geometry and index-width helper for the EEG frame path.
package eeg_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PARITY} eeg_state_e;
    localparam int EEG_WIDTH  = 4;
    localparam int EEG_NUM_CH = 8;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/eeg_deser_core.sv
// eeg_deser_core: LSB-first deserializer; the top bit of o_word is the live input, so a word is
// complete in the same cycle its last bit arrives.
module eeg_deser_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_din,
    output logic [WIDTH-1:0] o_word
);
    logic [WIDTH-2:0] r_q;
    assign o_word = {i_din, r_q};
    always_ff @(posedge clk) begin
        if (i_clr)
            r_q <= '0;
        else if (i_en)
            r_q <= o_word[WIDTH-1:1];
    end
endmodule

// File: rtl/eeg_frame_ctrl.sv
// eeg_frame_ctrl: frame-sync driven EEG deserializer with channel tagging and a one-entry output register.
// Define EEG_PARITY_EN to expect one even-parity bit after every word and flag mismatches in parity_err.
module eeg_frame_ctrl
    import eeg_pkg::*;
#(
    parameter int WIDTH  = EEG_WIDTH,
    parameter int NUM_CH = EEG_NUM_CH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sEEG,
    input  logic                      frame_sync,
    output logic [WIDTH-1:0]          word_out,
    output logic [idx_w(NUM_CH)-1:0]  ch_idx,
    output logic                      word_valid,
    input  logic                      word_ready,
    output logic                      frame_done,
    output logic                      busy,
    output logic                      overrun,
    output logic                      parity_err
);
    localparam int CW = idx_w(NUM_CH);
    localparam int BW = idx_w(WIDTH);
`ifdef EEG_PARITY_EN
    localparam int DW = WIDTH + 1;
`else
    localparam int DW = WIDTH;
`endif

    eeg_state_e      r_state;
    logic [BW-1:0]   r_bit_cnt;
    logic [CW-1:0]   r_ch_cnt;
    logic [WIDTH-1:0] r_word;
    logic [CW-1:0]   r_ch_idx;
    logic            r_valid;
    logic            r_frame_done;
    logic            r_overrun;
    logic [DW-1:0]   w_word;
    logic            w_en;
    logic            w_cap;
    logic            w_load;
    logic            w_last_bit;
    logic            w_last_ch;

    assign w_en       = (r_state != ST_IDLE) && !frame_sync;
    assign w_last_bit = r_bit_cnt == BW'(WIDTH - 1);
    assign w_last_ch  = r_ch_cnt == CW'(NUM_CH - 1);
`ifdef EEG_PARITY_EN
    assign w_cap      = w_en && (r_state == ST_PARITY);
`else
    assign w_cap      = w_en && (r_state == ST_SHIFT) && w_last_bit;
`endif
    // A draining transfer frees the register in the same cycle, so the new word may overwrite it.
    assign w_load     = w_cap && (!r_valid || word_ready);

    eeg_deser_core #(.WIDTH(DW)) u_deser (
        .clk    (clk),
        .i_en   (w_en),
        .i_clr  (frame_sync),
        .i_din  (sEEG),
        .o_word (w_word)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= '0;
            r_ch_cnt     <= '0;
            r_word       <= '0;
            r_ch_idx     <= '0;
            r_valid      <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_done <= w_cap && w_last_ch;
            if (frame_sync) begin
                r_state   <= ST_SHIFT;
                r_bit_cnt <= '0;
                r_ch_cnt  <= '0;
            end else if (w_cap) begin
                r_bit_cnt <= '0;
                r_ch_cnt  <= w_last_ch ? '0 : r_ch_cnt + CW'(1);
                r_state   <= w_last_ch ? ST_IDLE : ST_SHIFT;
            end else if (r_state == ST_SHIFT) begin
                r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + BW'(1);
`ifdef EEG_PARITY_EN
                if (w_last_bit)
                    r_state <= ST_PARITY;
`endif
            end
            if (w_load) begin
                r_word   <= w_word[WIDTH-1:0];
                r_ch_idx <= r_ch_cnt;
                r_valid  <= 1'b1;
            end else if (word_ready) begin
                r_valid  <= 1'b0;
            end
            if (w_cap && !w_load)
                r_overrun <= 1'b1;
        end
    end

`ifdef EEG_PARITY_EN
    logic r_parity_err;
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_parity_err <= 1'b0;
        else if (w_cap && ^w_word)
            r_parity_err <= 1'b1;
    end
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign word_out   = r_word;
    assign ch_idx     = r_ch_idx;
    assign word_valid = r_valid;
    assign frame_done = r_frame_done;
    assign busy       = r_state != ST_IDLE;
    assign overrun    = r_overrun;
endmodule

// File: tb/tb_eeg_frame_ctrl.sv
// tb_eeg_frame_ctrl: directed checks of eeg_frame_ctrl with WIDTH=4, NUM_CH=2.
module tb_eeg_frame_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sEEG = 1'b0;
    logic       frame_sync = 1'b0;
    logic       word_ready = 1'b1;
    logic [3:0] word_out;
    logic [0:0] ch_idx;
    logic       word_valid;
    logic       frame_done;
    logic       busy;
    logic       overrun;
    logic       parity_err;
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    eeg_frame_ctrl #(.WIDTH(4), .NUM_CH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sEEG       (sEEG),
        .frame_sync (frame_sync),
        .word_out   (word_out),
        .ch_idx     (ch_idx),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .frame_done (frame_done),
        .busy       (busy),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sync_pulse;
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
    endtask

    task automatic send_bits(input logic [3:0] w, input int n);
        for (int k = 0; k < n; k++) begin
            sEEG = w[k];
            tick();
        end
    endtask

    task automatic send_word(input logic [3:0] w, input logic p);
        send_bits(w, 4);
`ifdef EEG_PARITY_EN
        sEEG = p;
        tick();
`else
        if (p === 1'bx) $display("unexpected parity input");
`endif
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            sEEG = i[0];
            frame_sync = i[1];
            tick();
        end
        frame_sync = 1'b0;
        chk("rst_word", word_out, 0);
        chk("rst_ch", ch_idx, 0);
        chk("rst_valid", word_valid, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_par", parity_err, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", busy, 0);

        sync_pulse();
        chk("f1_busy_start", busy, 1);
        send_word(4'hD, 1'b1);
        chk("f1_w0_valid", word_valid, 1);
        chk("f1_w0_word", word_out, 4'hD);
        chk("f1_w0_ch", ch_idx, 0);
        chk("f1_w0_done", frame_done, 0);
        chk("f1_w0_busy", busy, 1);
        send_word(4'h2, 1'b1);
        chk("f1_w1_valid", word_valid, 1);
        chk("f1_w1_word", word_out, 4'h2);
        chk("f1_w1_ch", ch_idx, 1);
        chk("f1_w1_done", frame_done, 1);
        chk("f1_w1_busy", busy, 0);
        tick();
        chk("f1_done_pulse", frame_done, 0);
        chk("f1_drained", word_valid, 0);

        sync_pulse();
        send_word(4'h3, 1'b0);
        chk("ab_w0_word", word_out, 4'h3);
        send_bits(4'hF, 2);
        sync_pulse();
        send_word(4'h6, 1'b0);
        chk("ab_word", word_out, 4'h6);
        chk("ab_ch", ch_idx, 0);
        chk("ab_done", frame_done, 0);
        chk("ab_busy", busy, 1);
        chk("ab_ovr", overrun, 0);
        chk("ab_par", parity_err, 0);
        send_word(4'h9, 1'b0);
        chk("ab_w1_word", word_out, 4'h9);
        chk("ab_w1_ch", ch_idx, 1);
        chk("ab_w1_done", frame_done, 1);
        tick();

        word_ready = 1'b0;
        sync_pulse();
        send_word(4'hA, 1'b0);
        chk("bp_w0_valid", word_valid, 1);
        chk("bp_w0_word", word_out, 4'hA);
        chk("bp_w0_ovr", overrun, 0);
        send_word(4'h5, 1'b0);
        chk("bp_hold_word", word_out, 4'hA);
        chk("bp_hold_ch", ch_idx, 0);
        chk("bp_hold_valid", word_valid, 1);
        chk("bp_ovr", overrun, 1);
        chk("bp_done", frame_done, 1);
        word_ready = 1'b1;
        tick();
        chk("bp_xfer_valid", word_valid, 0);
        chk("bp_ovr_sticky", overrun, 1);

`ifdef EEG_PARITY_EN
        sync_pulse();
        send_word(4'hD, 1'b0);
        chk("par_word", word_out, 4'hD);
        chk("par_valid", word_valid, 1);
        chk("par_err", parity_err, 1);
        send_word(4'hD, 1'b1);
        chk("par_w1_word", word_out, 4'hD);
        chk("par_w1_ch", ch_idx, 1);
        chk("par_sticky", parity_err, 1);
        tick();
`else
        chk("par_tied", parity_err, 0);
`endif

        word_ready = 1'b0;
        sync_pulse();
        send_word(4'h4, 1'b1);
        chk("mr_pending", word_valid, 1);
        send_bits(4'hF, 2);
        rst_n = 1'b0;
        tick();
        chk("mr_valid", word_valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_word", word_out, 0);
        chk("mr_ovr", overrun, 0);
        chk("mr_par", parity_err, 0);
        rst_n = 1'b1;
        word_ready = 1'b1;
        tick();
        sync_pulse();
        send_word(4'h7, 1'b1);
        chk("mr_w0_word", word_out, 4'h7);
        chk("mr_w0_ch", ch_idx, 0);
        send_word(4'h8, 1'b1);
        chk("mr_w1_word", word_out, 4'h8);
        chk("mr_w1_ch", ch_idx, 1);
        chk("mr_w1_done", frame_done, 1);
        chk("mr_ovr_clean", overrun, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
